// File: rtl/osd_pkg.sv
// Shared types and command constants for the OSD command sequencer.
// The info-word helpers are only exercised when OSD_CMD_SEQ_INFO_EN is defined.
package osd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_FETCH,
    S_DATA,
    S_HOLD
  } state_e;

  localparam logic [7:0]  CMD_ENABLE    = 8'h41;
  localparam logic [7:0]  CMD_DISABLE   = 8'h40;
  localparam logic [7:0]  CMD_WRITE     = 8'h20;
  localparam int          CMD_INFO_BIT  = 2;
  localparam int          CMD_HIRES_BIT = 3;
  localparam logic [12:0] LEN_MAX       = 13'd4096;
  localparam logic [12:0] INFO_LEN      = 13'd5;

  function automatic logic is_info(input logic [7:0] c);
    return (c[7:4] == 4'h4) && c[CMD_INFO_BIT];
  endfunction

  function automatic logic [12:0] clamp_len(input logic [12:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

endpackage

// File: rtl/osd_strobe_timer.sv
// Word strobe generator: after start, strobe high STB_HI cycles, low STB_LO.
// done_o is a combinational pulse on the last low cycle.
module osd_strobe_timer #(
  parameter int unsigned STB_HI = 2,
  parameter int unsigned STB_LO = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic strobe_o,
  output logic done_o
);

  localparam logic [3:0] HI_M1 = 4'(STB_HI - 1);
  localparam logic [3:0] LO_M1 = 4'(STB_LO - 1);

  logic [3:0] cnt_q;
  logic       run_q;
  logic       lo_q;
  logic       stb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      lo_q  <= 1'b0;
      stb_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= HI_M1;
      run_q <= 1'b1;
      lo_q  <= 1'b0;
      stb_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end else if (!lo_q) begin
        cnt_q <= LO_M1;
        lo_q  <= 1'b1;
        stb_q <= 1'b0;
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign strobe_o = stb_q;
  assign done_o   = run_q && lo_q && (cnt_q == 4'd0);

endmodule

// File: rtl/osd_cmd_seq.sv
// OSD command sequencer: command word, then fetched or generated data words.
// Define OSD_CMD_SEQ_INFO_EN to enable generated info words for info commands.
module osd_cmd_seq
  import osd_pkg::*;
#(
  parameter int unsigned STB_HI = 2,
  parameter int unsigned STB_LO = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [12:0] req_len,
  output logic        dat_rd,
  output logic [12:0] dat_addr,
  input  logic [15:0] dat_in,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
`ifdef OSD_CMD_SEQ_INFO_EN
  input  logic [11:0] info_x,
  input  logic [11:0] info_y,
  input  logic [5:0]  info_w,
  input  logic [5:0]  info_h,
  input  logic [1:0]  info_rot,
`endif
  output logic        busy
);

  localparam logic [4:0] LO_M1   = 5'(STB_LO - 1);
  localparam logic [4:0] LO_C    = 5'(STB_LO);
  localparam logic [4:0] HOLD_M1 = 5'(2 * STB_LO - 1);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [12:0] len_q;
  logic [12:0] wcnt_q;
  logic [7:0]  cmd_q;
  logic        fph_q;
  logic        rdy_q;
  logic        busy_q;
  logic        osd_q;
  logic        rd_q;
  logic [12:0] addr_q;
  logic [15:0] din_q;

  logic        accept;
  logic        more;
  logic        tmr_start;
  logic        tmr_done;
  logic        fetch_rd;
  logic [15:0] fetch_word;
  logic [12:0] acc_len;

  assign accept = (state_q == S_IDLE) && req_valid && rdy_q;
  assign more   = wcnt_q < len_q;
  assign tmr_start = ((state_q == S_SETUP) && (cnt_q == 5'd0)) ||
                     ((state_q == S_FETCH) && fph_q);

`ifdef OSD_CMD_SEQ_INFO_EN
  logic        info_q;
  logic [11:0] ix_q;
  logic [11:0] iy_q;
  logic [5:0]  iw_q;
  logic [5:0]  ih_q;
  logic [1:0]  irot_q;
  logic [15:0] info_word;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      info_q <= 1'b0;
      ix_q   <= '0;
      iy_q   <= '0;
      iw_q   <= '0;
      ih_q   <= '0;
      irot_q <= '0;
    end else if (accept) begin
      info_q <= is_info(req_cmd);
      ix_q   <= info_x;
      iy_q   <= info_y;
      iw_q   <= info_w;
      ih_q   <= info_h;
      irot_q <= info_rot;
    end
  end

  // wcnt_q has already advanced past the word being captured
  always_comb begin
    info_word = {14'h0, irot_q};
    unique case (wcnt_q)
      13'd1:   info_word = {4'h0, ix_q};
      13'd2:   info_word = {4'h0, iy_q};
      13'd3:   info_word = {10'h0, iw_q};
      13'd4:   info_word = {10'h0, ih_q};
      default: info_word = {14'h0, irot_q};
    endcase
  end

  assign fetch_rd   = !info_q;
  assign fetch_word = info_q ? info_word : dat_in;
  assign acc_len    = is_info(req_cmd) ? INFO_LEN : clamp_len(req_len);
`else
  assign fetch_rd   = 1'b1;
  assign fetch_word = dat_in;
  assign acc_len    = clamp_len(req_len);
`endif

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      cmd_q   <= '0;
      fph_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      osd_q   <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            osd_q   <= 1'b1;
            cnt_q   <= LO_M1;
            cmd_q   <= req_cmd;
            len_q   <= acc_len;
            wcnt_q  <= '0;
            state_q <= S_SETUP;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt_q == 5'd0) begin
            din_q   <= {8'h00, cmd_q};
            state_q <= S_CMD;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_CMD, S_DATA: begin
          if (tmr_done) begin
            if (more) begin
              fph_q   <= 1'b0;
              state_q <= S_FETCH;
              if (fetch_rd) begin
                rd_q   <= 1'b1;
                addr_q <= wcnt_q;
              end
            end else begin
              cnt_q   <= HOLD_M1;
              state_q <= S_HOLD;
            end
          end
        end
        S_FETCH: begin
          if (!fph_q) begin
            rd_q   <= 1'b0;
            wcnt_q <= wcnt_q + 13'd1;
            fph_q  <= 1'b1;
          end else begin
            din_q   <= fetch_word;
            state_q <= S_DATA;
          end
        end
        S_HOLD: begin
          // io_osd hold after the last strobe, then a guaranteed low gap
          if (cnt_q == LO_C) osd_q <= 1'b0;
          if (cnt_q == 5'd0) begin
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  osd_strobe_timer #(
    .STB_HI(STB_HI),
    .STB_LO(STB_LO)
  ) u_tmr (
    .clk_i   (clk_sys),
    .rst_i   (rst),
    .start_i (tmr_start),
    .strobe_o(io_strobe),
    .done_o  (tmr_done)
  );

  assign req_ready = rdy_q;
  assign busy      = busy_q;
  assign io_osd    = osd_q;
  assign dat_rd    = rd_q;
  assign dat_addr  = addr_q;
  assign io_din    = din_q;

endmodule
